// File: rtl/flash_read_responder.sv
// ---------------------------------------------------------------------------
// flash_read_responder
//
// Read-only Avalon-MM responder that emulates the on-board flash behind the
// flash address controller. It accepts one word read at a time and answers
// with a deterministic, address-derived 32-bit word after a programmable
// latency. Benches and no-flash builds use it in place of the vendor flash IP.
//
// Parameters
//   STALL    cycles waitrequest stays high after read is first seen (0..15)
//   LATENCY  cycles from acceptance to the readdatavalid pulse (1..15)
//   SEED     byte XOR mask applied to every returned byte
//
// Ports
//   clk                      system clock, rising edge
//   reset_n                  asynchronous active-low reset
//   flash_mem_address        [22:0] word address, sampled only at acceptance
//   flash_mem_read           read request, held high until accepted
//   flash_mem_waitrequest    high = request not accepted this cycle
//   flash_mem_readdata       [31:0] returned word, qualified by readdatavalid
//   flash_mem_readdatavalid  one-cycle pulse marking readdata
//   read_count               [15:0] completed responses, wraps to 0
//   protocol_err             sticky; read dropped while waitrequest was high
// ---------------------------------------------------------------------------
module flash_read_responder #(
    parameter int unsigned STALL   = 2,
    parameter int unsigned LATENCY = 3,
    parameter logic [7:0]  SEED    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [22:0] flash_mem_address,
    input  logic        flash_mem_read,
    output logic        flash_mem_waitrequest,
    output logic [31:0] flash_mem_readdata,
    output logic        flash_mem_readdatavalid,
    output logic [15:0] read_count,
    output logic        protocol_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STALL,
        S_ACCEPT,
        S_LAT,
        S_RESP
    } state_t;

    // Counter reload values; STALL=0 never uses its reload, so guard the
    // subtraction against wrapping.
    localparam logic [3:0] STALL_LOAD = 4'((STALL > 0) ? (STALL - 1) : 0);
    localparam logic [3:0] LAT_LOAD   = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

    // Byte k of the response is {a[5:0], k} ^ SEED, byte 0 in bits 7:0.
    function automatic logic [31:0] word_for(input logic [5:0] a);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            w[8*k +: 8] = {a, 2'(k)} ^ SEED;
        end
        return w;
    endfunction

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    // Only the low six address bits shape the response word.
    logic [5:0]  addr_q, addr_d;
    logic        err_set;

    logic        waitrequest_d;
    logic        readdatavalid_d;
    logic [31:0] readdata_d;
    logic [15:0] read_count_d;
    logic        protocol_err_d;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^flash_mem_address[22:6];

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= S_IDLE;
            cnt                     <= '0;
            addr_q                  <= '0;
            flash_mem_waitrequest   <= 1'b1;
            flash_mem_readdatavalid <= 1'b0;
            flash_mem_readdata      <= '0;
            read_count              <= '0;
            protocol_err            <= 1'b0;
        end else begin
            state                   <= state_d;
            cnt                     <= cnt_d;
            addr_q                  <= addr_d;
            flash_mem_waitrequest   <= waitrequest_d;
            flash_mem_readdatavalid <= readdatavalid_d;
            flash_mem_readdata      <= readdata_d;
            read_count              <= read_count_d;
            protocol_err            <= protocol_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        err_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (flash_mem_read) begin
                    if (STALL == 0) begin
                        state_d = S_ACCEPT;
                    end else begin
                        state_d = S_STALL;
                        cnt_d   = STALL_LOAD;
                    end
                end
            end
            S_STALL: begin
                // A dropped request is checked before the count so an
                // abandoned read never reaches acceptance.
                if (!flash_mem_read) begin
                    state_d = S_IDLE;
                    err_set = 1'b1;
                end else if (cnt == 4'd0) begin
                    state_d = S_ACCEPT;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_ACCEPT: begin
                if (flash_mem_read) begin
                    state_d = S_LAT;
                    cnt_d   = LAT_LOAD;
                    addr_d  = flash_mem_address[5:0];
                end else begin
                    state_d = S_IDLE;
                    err_set = 1'b1;
                end
            end
            S_LAT: begin
                if (cnt == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: outputs are registered, so they are decoded from the
    // state being entered rather than the current one.
    always_comb begin
        waitrequest_d   = (state_d != S_ACCEPT);
        readdatavalid_d = (state_d == S_RESP);
        readdata_d      = flash_mem_readdata;
        read_count_d    = read_count;
        protocol_err_d  = protocol_err | err_set;
        if (state_d == S_RESP) begin
            readdata_d   = word_for(addr_q);
            read_count_d = read_count + 16'd1;
        end
    end

endmodule
